// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, decoder
// instruction classes and next-PC source selects.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALTED  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LD   = 3'd1,
    CLS_ST   = 3'd2,
    CLS_BR   = 3'd3,
    CLS_JMP  = 3'd4,
    CLS_CALL = 3'd5,
    CLS_RET  = 3'd6,
    CLS_HALT = 3'd7
  } icls_t;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;  // pc + 2
  localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd2;
  localparam logic [1:0] PC_SEL_R7     = 2'd3;  // return address register

endpackage

// File: rtl/mc_timeout_counter.sv
// Memory-wait watchdog: counts consecutive wait cycles, flags the last allowed one.
// Latency: expired is combinational on the current count and inc.
// Backpressure: none; clr has priority over inc.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the count (state entry)
//   inc        : a wait cycle is being spent (ready still low)
//   expired    : this wait cycle is the MEM_TMO-th one; 0 when MEM_TMO == 0
module mc_timeout_counter #(
  parameter int MEM_TMO = 15,
  parameter int TMO_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TMO - 1);

  logic [TMO_W-1:0] cnt;

  // cnt holds the number of wait cycles already spent, so the MEM_TMO-th
  // waiting cycle is the one that starts with cnt == MEM_TMO-1.
  assign expired = (MEM_TMO != 0) && inc && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {TMO_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the 16-bit RISC core (FETCH/DECODE/EXECUTE/MEM/WB).
// Latency: 2 (JMP/RET) to 5 (LD) cycles per instruction with immediate ready and no stall.
// Backpressure: waits on imem_ready/dmem_ready (timeout trap); stall freezes DECODE/EXECUTE/WB.
//   clk, reset            : clock, synchronous active-high reset (all outputs 0 while high)
//   icls, br_taken, stall : decoder class, branch outcome, external freeze
//   imem_ready/dmem_ready : memory handshakes; imem_req/dmem_req/dmem_we requests
//   ir_we..memwb_we       : pipeline latch loads; reg_we, pc_we, pc_sel datapath controls
//   state_o, trap         : current state, sticky memory timeout
//   retired, cycles       : saturating instruction and cycle counters
module multicycle_sequencer #(
  parameter int PC_W    = 16,
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 15,
  parameter int TMO_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       icls,
  input  logic             br_taken,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state_o,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);
  import mc_pkg::*;

  generate
    if (PC_W < 2 || (2 ** TMO_W) <= MEM_TMO) begin : g_bad_params
      $error("multicycle_sequencer: PC_W must be >= 2 and 2**TMO_W must exceed MEM_TMO");
    end
  endgenerate

  state_t           state, state_nx;
  icls_t            cls_q, cls_eff;
  logic             trap_q;
  logic [CNT_W-1:0] retired_q, cycles_q;

  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, idex_we_c;
  logic       exmem_we_c, memwb_we_c, reg_we_c, pc_we_c, retire_c;
  logic [1:0] pc_sel_c;
  logic       tmo_inc, tmo_clr, tmo_expired;

  // In DECODE the class is being latched this very cycle, so decisions use
  // the live decoder input; later states use the latched copy.
  assign cls_eff = (state == ST_DECODE) ? icls_t'(icls) : cls_q;

  always_comb begin
    state_nx   = state;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_we_c    = 1'b0;
    idex_we_c  = 1'b0;
    exmem_we_c = 1'b0;
    memwb_we_c = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = PC_SEL_SEQ;
    retire_c   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c  = 1'b1;
          state_nx = ST_DECODE;
        end else if (tmo_expired) begin
          state_nx = ST_HALTED;
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          idex_we_c = 1'b1;
          case (cls_eff)
            CLS_JMP: begin
              pc_we_c  = 1'b1;
              pc_sel_c = PC_SEL_JUMP;
              retire_c = 1'b1;
              state_nx = ST_FETCH;
            end
            CLS_CALL: begin
              // Target is presented now; the PC loads in WB after R7 is written.
              pc_sel_c = PC_SEL_JUMP;
              state_nx = ST_WB;
            end
            CLS_RET: begin
              pc_we_c  = 1'b1;
              pc_sel_c = PC_SEL_R7;
              retire_c = 1'b1;
              state_nx = ST_FETCH;
            end
            CLS_HALT: state_nx = ST_HALTED;
            default:  state_nx = ST_EXECUTE;
          endcase
        end
      end
      ST_EXECUTE: begin
        if (!stall) begin
          exmem_we_c = 1'b1;
          case (cls_eff)
            CLS_BR: begin
              pc_we_c  = 1'b1;
              pc_sel_c = br_taken ? PC_SEL_BRANCH : PC_SEL_SEQ;
              retire_c = 1'b1;
              state_nx = ST_FETCH;
            end
            CLS_LD, CLS_ST: state_nx = ST_MEM;
            default:        state_nx = ST_WB;
          endcase
        end
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls_eff == CLS_ST);
        if (dmem_ready) begin
          memwb_we_c = 1'b1;
          if (cls_eff == CLS_ST) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_WB;
          end
        end else if (tmo_expired) begin
          state_nx = ST_HALTED;
        end
      end
      ST_WB: begin
        if (!stall) begin
          reg_we_c = 1'b1;
          pc_we_c  = 1'b1;
          pc_sel_c = (cls_eff == CLS_CALL) ? PC_SEL_JUMP : PC_SEL_SEQ;
          retire_c = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_HALTED: state_nx = ST_HALTED;
      default:   state_nx = ST_FETCH;  // unused encodings recover silently
    endcase
  end

  assign tmo_inc = ((state == ST_FETCH) && !imem_ready) ||
                   ((state == ST_MEM) && !dmem_ready);
  assign tmo_clr = (state_nx != state);

  mc_timeout_counter #(
    .MEM_TMO(MEM_TMO),
    .TMO_W  (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      cls_q     <= CLS_ALU;
      trap_q    <= 1'b0;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_DECODE) cls_q <= icls_t'(icls);
      if (tmo_expired) trap_q <= 1'b1;
      if (cycles_q != {CNT_W{1'b1}}) cycles_q <= cycles_q + 1'b1;
      if (retire_c && (retired_q != {CNT_W{1'b1}})) retired_q <= retired_q + 1'b1;
    end
  end

  // Reset forces every output low, so an abandoned instruction cannot emit
  // a PC or register write in the reset cycle.
  assign imem_req = !reset && imem_req_c;
  assign dmem_req = !reset && dmem_req_c;
  assign dmem_we  = !reset && dmem_we_c;
  assign ir_we    = !reset && ir_we_c;
  assign idex_we  = !reset && idex_we_c;
  assign exmem_we = !reset && exmem_we_c;
  assign memwb_we = !reset && memwb_we_c;
  assign reg_we   = !reset && reg_we_c;
  assign pc_we    = !reset && pc_we_c;
  assign pc_sel   = reset ? PC_SEL_SEQ : pc_sel_c;
  assign state_o  = reset ? 3'd0 : state;
  assign trap     = !reset && trap_q;
  assign retired  = reset ? '0 : retired_q;
  assign cycles   = reset ? '0 : cycles_q;

endmodule
